// File: rtl/cpu_mem_bridge.sv
// cpu_mem_bridge: bridges the Cpu level-request memory port onto TestRam cycles.
//
// A transaction is accepted when cpu_req_rdwr is high and the bridge is armed (req was seen
// low since the previous accept). In-window writes issue a single-cycle ram_we pulse; in-window
// reads wait for ram_data_ready up to TIMEOUT cycles, returning ERR_DATA and setting the sticky
// bus_err on expiry. Out-of-window accesses never touch TestRam and complete immediately; reads
// there return the previous cpu_data_in. Every transaction ends with a one-cycle cpu_ack.
//
// Ports:
//   clk            single clock shared with TestRam
//   rst            asynchronous active-high reset
//   cpu_req_rdwr   Cpu request, held high until cpu_ack
//   cpu_which_rdwr 0 = read, 1 = write
//   cpu_addr       request address (upper bits select the RAM bank)
//   cpu_data_out   write data from the Cpu
//   cpu_data_in    registered read data to the Cpu
//   cpu_ack        one-cycle completion pulse
//   ram_we         TestRam write enable
//   ram_addr       registered TestRam address
//   ram_data_in    registered TestRam write data
//   ram_data_out   TestRam read data
//   ram_data_ready TestRam read data valid
//   bus_err        sticky read-timeout flag

module cpu_mem_bridge #(
  parameter int unsigned               CPU_ADDR_WIDTH = 24,
  parameter int unsigned               RAM_ADDR_WIDTH = 16,
  parameter int unsigned               DATA_WIDTH     = 8,
  parameter int unsigned               RAM_BANK       = 0,
  parameter int unsigned               TIMEOUT        = 15,
  parameter logic [DATA_WIDTH-1:0]     ERR_DATA       = DATA_WIDTH'(8'hFF)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cpu_req_rdwr,
  input  logic                      cpu_which_rdwr,
  input  logic [CPU_ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0]     cpu_data_out,
  output logic [DATA_WIDTH-1:0]     cpu_data_in,
  output logic                      cpu_ack,
  output logic                      ram_we,
  output logic [RAM_ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0]     ram_data_in,
  input  logic [DATA_WIDTH-1:0]     ram_data_out,
  input  logic                      ram_data_ready,
  output logic                      bus_err
);

  localparam int unsigned BankW = CPU_ADDR_WIDTH - RAM_ADDR_WIDTH;
  localparam int unsigned CntW  = $clog2(TIMEOUT + 1);

  localparam logic [BankW-1:0] BankSel  = BankW'(RAM_BANK);
  localparam logic [CntW-1:0]  CntLast  = CntW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    StIdle,
    StWrite,
    StReadWait,
    StDone
  } state_e;

  state_e                    state_q, state_d;
  logic [DATA_WIDTH-1:0]     cpu_data_in_q, cpu_data_in_d;
  logic                      cpu_ack_q, cpu_ack_d;
  logic                      ram_we_q, ram_we_d;
  logic [RAM_ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_WIDTH-1:0]     ram_data_in_q, ram_data_in_d;
  logic                      bus_err_q, bus_err_d;
  logic [CntW-1:0]           cnt_q, cnt_d;
  logic                      armed_q, armed_d;

  logic in_window;
  logic accept;

  assign in_window = (cpu_addr[CPU_ADDR_WIDTH-1:RAM_ADDR_WIDTH] == BankSel);
  assign accept    = (state_q == StIdle) && cpu_req_rdwr && armed_q;

  always_comb begin
    state_d       = state_q;
    cpu_data_in_d = cpu_data_in_q;
    cpu_ack_d     = 1'b0;
    ram_we_d      = 1'b0;
    ram_addr_d    = ram_addr_q;
    ram_data_in_d = ram_data_in_q;
    bus_err_d     = bus_err_q;
    cnt_d         = cnt_q;
    // A request still high after its ack must not be taken again until req drops.
    if (!cpu_req_rdwr) begin
      armed_d = 1'b1;
    end else if (accept) begin
      armed_d = 1'b0;
    end else begin
      armed_d = armed_q;
    end

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          ram_addr_d    = cpu_addr[RAM_ADDR_WIDTH-1:0];
          ram_data_in_d = cpu_data_out;
          if (!in_window) begin
            // Open bus: no RAM cycle, reads keep the previous cpu_data_in.
            state_d   = StDone;
            cpu_ack_d = 1'b1;
          end else if (cpu_which_rdwr) begin
            state_d  = StWrite;
            ram_we_d = 1'b1;
          end else begin
            state_d = StReadWait;
            cnt_d   = '0;
          end
        end
      end

      StWrite: begin
        state_d   = StDone;
        cpu_ack_d = 1'b1;
      end

      StReadWait: begin
        if (ram_data_ready) begin
          cpu_data_in_d = ram_data_out;
          state_d       = StDone;
          cpu_ack_d     = 1'b1;
        end else if (cnt_q == CntLast) begin
          cpu_data_in_d = ERR_DATA;
          bus_err_d     = 1'b1;
          state_d       = StDone;
          cpu_ack_d     = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      cpu_data_in_q <= '0;
      cpu_ack_q     <= 1'b0;
      ram_we_q      <= 1'b0;
      ram_addr_q    <= '0;
      ram_data_in_q <= '0;
      bus_err_q     <= 1'b0;
      cnt_q         <= '0;
      armed_q       <= 1'b1;
    end else begin
      state_q       <= state_d;
      cpu_data_in_q <= cpu_data_in_d;
      cpu_ack_q     <= cpu_ack_d;
      ram_we_q      <= ram_we_d;
      ram_addr_q    <= ram_addr_d;
      ram_data_in_q <= ram_data_in_d;
      bus_err_q     <= bus_err_d;
      cnt_q         <= cnt_d;
      armed_q       <= armed_d;
    end
  end

  assign cpu_data_in = cpu_data_in_q;
  assign cpu_ack     = cpu_ack_q;
  assign ram_we      = ram_we_q;
  assign ram_addr    = ram_addr_q;
  assign ram_data_in = ram_data_in_q;
  assign bus_err     = bus_err_q;

endmodule

// File: tb/tb_cpu_mem_bridge.sv
// Scoreboard bench for cpu_mem_bridge: the stimulus process predicts each transaction's result
// from a simple memory model and pushes it into queues; monitors pop and compare whenever the
// DUT pulses cpu_ack or ram_we.

module tb_cpu_mem_bridge;

  localparam int TIMEOUT = 15;

  logic        clk;
  logic        rst;
  logic        cpu_req_rdwr;
  logic        cpu_which_rdwr;
  logic [23:0] cpu_addr;
  logic [7:0]  cpu_data_out;
  logic [7:0]  cpu_data_in;
  logic        cpu_ack;
  logic        ram_we;
  logic [15:0] ram_addr;
  logic [7:0]  ram_data_in;
  logic [7:0]  ram_data_out;
  logic        ram_data_ready;
  logic        bus_err;

  cpu_mem_bridge #(
    .CPU_ADDR_WIDTH (24),
    .RAM_ADDR_WIDTH (16),
    .DATA_WIDTH     (8),
    .RAM_BANK       (0),
    .TIMEOUT        (TIMEOUT),
    .ERR_DATA       (8'hFF)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .cpu_req_rdwr   (cpu_req_rdwr),
    .cpu_which_rdwr (cpu_which_rdwr),
    .cpu_addr       (cpu_addr),
    .cpu_data_out   (cpu_data_out),
    .cpu_data_in    (cpu_data_in),
    .cpu_ack        (cpu_ack),
    .ram_we         (ram_we),
    .ram_addr       (ram_addr),
    .ram_data_in    (ram_data_in),
    .ram_data_out   (ram_data_out),
    .ram_data_ready (ram_data_ready),
    .bus_err        (bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural TestRam; read data is only meaningful while ram_sel is set by the stimulus.
  logic [7:0] ram_mem [0:65535];
  logic       ram_sel;
  logic [7:0] noise;
  always @(posedge clk) if (ram_we) ram_mem[ram_addr] <= ram_data_in;
  assign ram_data_out = ram_sel ? ram_mem[ram_addr] : noise;

  typedef struct {
    logic [7:0] data;
    logic       err;
    int         cyc;
  } ack_exp_t;

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  data;
    int          cyc;
  } wr_exp_t;

  ack_exp_t ackq[$];
  wr_exp_t  wrq[$];

  // Reference model state
  logic [7:0] m_mem [0:65535];
  logic [7:0] m_last;
  logic       m_err;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard monitors
  always @(negedge clk) begin
    if (!rst) begin
      if (cpu_ack) begin
        if (ackq.size() == 0) begin
          chk("unexpected_ack", 1, 0);
        end else begin
          ack_exp_t e;
          e = ackq.pop_front();
          chk("ack_cycle", cyc, e.cyc);
          chk("rdata", cpu_data_in, e.data);
          chk("bus_err", bus_err, e.err);
        end
      end
      if (ram_we) begin
        if (wrq.size() == 0) begin
          chk("unexpected_ram_we", 1, 0);
        end else begin
          wr_exp_t w;
          w = wrq.pop_front();
          chk("we_cycle", cyc, w.cyc);
          chk("ram_addr", ram_addr, w.addr);
          chk("ram_data_in", ram_data_in, w.data);
        end
      end
    end
  end

  // Issue one transaction at a negedge; d = READ_WAIT cycles with ready low before it rises.
  task automatic do_txn(input logic wr, input logic [23:0] a, input logic [7:0] wd,
                        input int d, input int hold);
    ack_exp_t e;
    wr_exp_t  w;
    int       acc;
    int       lat;
    bit       inwin;
    bit       rd;
    bit       got;
    cpu_which_rdwr = wr;
    cpu_addr       = a;
    cpu_data_out   = wd;
    cpu_req_rdwr   = 1'b1;
    acc   = cyc + 1;
    inwin = (a[23:16] == 8'h00);
    rd    = inwin && !wr;
    if (!inwin) begin
      lat = 0;
    end else if (wr) begin
      lat = 1;
      m_mem[a[15:0]] = wd;
      w.addr = a[15:0];
      w.data = wd;
      w.cyc  = acc;
      wrq.push_back(w);
    end else if (d < TIMEOUT) begin
      lat    = d + 1;
      m_last = m_mem[a[15:0]];
    end else begin
      lat    = TIMEOUT;
      m_last = 8'hFF;
      m_err  = 1'b1;
    end
    e.data = m_last;
    e.err  = m_err;
    e.cyc  = acc + lat;
    ackq.push_back(e);

    got = 1'b0;
    for (int k = 0; k < 60 && !got; k++) begin
      @(negedge clk);
      if (cpu_ack) begin
        got = 1'b1;
      end else begin
        // Latched inputs may wander after accept.
        cpu_addr     = 24'($urandom);
        cpu_data_out = 8'($urandom);
        noise        = 8'($urandom);
        if (rd) begin
          ram_data_ready = (k >= d);
          ram_sel        = (k >= d);
        end else begin
          ram_data_ready = 1'($urandom);
          ram_sel        = 1'b0;
        end
      end
    end
    if (!got) chk("ack_wait_timeout", 0, 1);
    ram_data_ready = 1'($urandom);
    ram_sel        = 1'b0;
    repeat (hold) @(negedge clk);
    cpu_req_rdwr = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst            = 1'b1;
    cpu_req_rdwr   = 1'b0;
    cpu_which_rdwr = 1'b0;
    cpu_addr       = '0;
    cpu_data_out   = '0;
    ram_data_ready = 1'b0;
    ram_sel        = 1'b0;
    noise          = 8'h00;
    m_last         = 8'h00;
    m_err          = 1'b0;
    for (int i = 0; i < 65536; i++) begin
      ram_mem[i] = 8'h00;
      m_mem[i]   = 8'h00;
    end
    repeat (3) @(negedge clk);
    chk("reset_cpu_data_in", cpu_data_in, 0);
    chk("reset_cpu_ack", cpu_ack, 0);
    chk("reset_ram_we", ram_we, 0);
    chk("reset_ram_addr", ram_addr, 0);
    chk("reset_ram_data_in", ram_data_in, 0);
    chk("reset_bus_err", bus_err, 0);
    rst = 1'b0;
    @(negedge clk);

    // Directed cases
    do_txn(1'b1, 24'h00_1234, 8'hA5, 0, 0);
    do_txn(1'b0, 24'h00_1234, 8'h00, 0, 0);
    do_txn(1'b1, 24'h00_2000, 8'h3C, 0, 1);
    do_txn(1'b0, 24'h00_2000, 8'h00, 5, 0);
    do_txn(1'b0, 24'h00_1234, 8'h00, TIMEOUT + 3, 0);
    do_txn(1'b0, 24'h00_1234, 8'h00, 1, 0);
    do_txn(1'b0, 24'h00_2000, 8'h00, TIMEOUT - 1, 0);
    do_txn(1'b1, 24'h01_0000, 8'h55, 0, 0);
    do_txn(1'b0, 24'h02_0000, 8'h00, 0, 3);
    do_txn(1'b0, 24'h01_0000, 8'h00, 0, 0);

    // Reset during the WRITE state
    cpu_which_rdwr = 1'b1;
    cpu_addr       = 24'h00_0042;
    cpu_data_out   = 8'h77;
    cpu_req_rdwr   = 1'b1;
    @(posedge clk);
    #2;
    chk("pre_rst_ram_we", ram_we, 1);
    chk("pre_rst_bus_err", bus_err, 1);
    rst = 1'b1;
    #1;
    chk("rst_ram_we", ram_we, 0);
    chk("rst_cpu_ack", cpu_ack, 0);
    chk("rst_bus_err", bus_err, 0);
    chk("rst_cpu_data_in", cpu_data_in, 0);
    @(negedge clk);
    cpu_req_rdwr = 1'b0;
    @(negedge clk);
    rst    = 1'b0;
    m_last = 8'h00;
    m_err  = 1'b0;
    @(negedge clk);
    do_txn(1'b0, 24'h00_0042, 8'h00, 2, 0);
    do_txn(1'b1, 24'h00_0042, 8'h99, 0, 0);
    do_txn(1'b0, 24'h00_0042, 8'h00, 0, 0);

    // Randomized traffic
    for (int n = 0; n < 150; n++) begin
      logic [23:0] a;
      logic        wr;
      int          d;
      a[15:0]  = 16'h4000 + 16'($urandom_range(0, 7));
      a[23:16] = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      wr       = 1'($urandom);
      d        = ($urandom_range(0, 7) == 0) ? $urandom_range(TIMEOUT - 1, TIMEOUT + 2)
                                             : $urandom_range(0, 6);
      do_txn(wr, a, 8'($urandom), d, $urandom_range(0, 2));
    end

    repeat (5) @(negedge clk);
    chk("ack_queue_drained", ackq.size(), 0);
    chk("write_queue_drained", wrq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
